// File: rtl/mxv_result_collector.sv
// mxv_result_collector: gathers row dot-product results into a readable buffer for one matrix-by-vector product.
// Optional MXV_COLLECT_STRAY_CHECK_EN builds a sticky flag for result strobes arriving outside COLLECT.
module mxv_result_collector #(
    parameter int element_width   = 32,
    parameter int row_index_width = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_mxv,
    input  logic [row_index_width:0]   no_of_rows,
    input  logic [element_width-1:0]   row_result,
    input  logic                       row_result_valid,
    output logic                       collector_ready,
    output logic [row_index_width:0]   row_index,
    output logic                       mxv_done,
    output logic                       results_valid,
    input  logic [row_index_width-1:0] rd_addr,
    output logic [element_width-1:0]   rd_data,
    output logic                       stray_result
);
    localparam logic [row_index_width:0] max_rows = {1'b1, {row_index_width{1'b0}}};

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                   state;
    logic                     run;
    logic [row_index_width:0] count;
    logic [row_index_width:0] rows_sat;
    logic                     wr_en;
    logic                     last;
    logic [element_width-1:0] buffer [2**row_index_width];

    assign rows_sat = (no_of_rows > max_rows) ? max_rows : no_of_rows;
    assign wr_en    = run && state == COLLECT && row_result_valid && !start_mxv;
    assign last     = (row_index + 1'b1) == count;

    // run holds the FSM still for the first edge after reset release
    always_ff @(posedge clk or negedge reset)
        if (!reset) run <= 1'b0;
        else        run <= 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            row_index       <= '0;
            mxv_done        <= 1'b0;
            results_valid   <= 1'b0;
            collector_ready <= 1'b0;
        end else if (run) begin
            mxv_done <= 1'b0;
            if (start_mxv) begin
                count           <= rows_sat;
                row_index       <= '0;
                state           <= rows_sat == '0 ? DONE : COLLECT;
                mxv_done        <= rows_sat == '0;
                results_valid   <= rows_sat == '0;
                collector_ready <= rows_sat != '0;
            end else begin
                case (state)
                    COLLECT: if (row_result_valid) begin
                        row_index <= row_index + 1'b1;
                        if (last) begin
                            state           <= DONE;
                            mxv_done        <= 1'b1;
                            results_valid   <= 1'b1;
                            collector_ready <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk)
        if (wr_en) buffer[row_index[row_index_width-1:0]] <= row_result;

    always_ff @(posedge clk or negedge reset)
        if (!reset) rd_data <= '0;
        else        rd_data <= buffer[rd_addr];

`ifdef MXV_COLLECT_STRAY_CHECK_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset)                                       stray_result <= 1'b0;
        else if (run && start_mxv)                        stray_result <= 1'b0;
        else if (run && row_result_valid && state != COLLECT) stray_result <= 1'b1;
`else
    assign stray_result = 1'b0;
`endif
endmodule

// File: doc/mxv_result_collector.md
MXV_RESULT_COLLECTOR -- requirements
Module: mxv_result_collector

Interface
REQ-001 Parameters (name, default, meaning): element_width, 32, width of one dot-product result; row_index_width, 6, buffer address width (MAX_ROWS = 2**row_index_width = 64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_mxv  input  1  one-cycle strobe; begins collection of a new matrix-by-vector result.
REQ-005 no_of_rows  input  row_index_width+1  rows expected; sampled only on start_mxv; legal range 0..MAX_ROWS.
REQ-006 row_result  input  element_width  dot-product result of the current row from the upstream row-by-vector stage.
REQ-007 row_result_valid  input  1  one-cycle strobe; row_result is valid this cycle (driven by the upstream decoder_read_now).
REQ-008 collector_ready  output  1  high while in COLLECT; upstream may launch rows only while high.
REQ-009 row_index  output  row_index_width+1  number of results stored so far in the current product.
REQ-010 mxv_done  output  1  one-cycle pulse when the last expected result has been stored.
REQ-011 results_valid  output  1  high in DONE; buffer holds a complete result vector.
REQ-012 rd_addr  input  row_index_width  read address into the result buffer.
REQ-013 rd_data  output  element_width  registered buffer contents at rd_addr.
REQ-014 stray_result  output  1  sticky error flag (present only per REQ-031).

Function
REQ-015 The FSM SHALL have three states: IDLE, COLLECT, DONE.
REQ-016 IDLE/DONE + start_mxv with no_of_rows > 0 -> COLLECT next cycle; the FSM latches no_of_rows and clears row_index.
REQ-017 start_mxv with no_of_rows = 0 -> DONE next cycle; mxv_done pulses in that cycle; the FSM writes nothing.
REQ-018 In COLLECT, each row_result_valid writes row_result to buffer[row_index[row_index_width-1:0]] and increments row_index by 1.
REQ-019 When the write makes row_index equal to the latched count, the FSM enters DONE on the next edge; mxv_done is high for exactly that first DONE cycle.
REQ-020 results_valid SHALL be high in every DONE cycle and low otherwise; collector_ready high only in COLLECT.
REQ-021 start_mxv in COLLECT aborts the product: row_index clears, the new count is latched, and the FSM stays in COLLECT (or enters DONE if the new count is 0); mxv_done does not pulse for the aborted product.
REQ-022 start_mxv and row_result_valid in the same cycle: start wins; the result is discarded and not written.
REQ-023 row_result_valid in IDLE or DONE SHALL NOT write the buffer or change row_index.
REQ-024 The buffer SHALL be read independently of state; rd_data = buffer[rd_addr] one cycle after rd_addr is applied (1-cycle latency).
REQ-025 A write and a read to the same address in the same cycle SHALL return the old data.
REQ-026 no_of_rows > MAX_ROWS SHALL be saturated to MAX_ROWS at latch time.

Reset
REQ-027 Assertion of reset (low) SHALL immediately force IDLE, row_index = 0, latched count = 0, mxv_done = 0, results_valid = 0, collector_ready = 0, rd_data = 0, stray_result = 0.
REQ-028 Buffer contents are not cleared by reset; contents are undefined until written.
REQ-029 Reset mid-COLLECT discards the partial product; after release the block waits in IDLE for start_mxv.
REQ-030 Reset deassertion is consumed synchronously; the first state change after release occurs no earlier than the second rising edge.

Configuration
REQ-031 Macro MXV_COLLECT_STRAY_CHECK_EN: when defined, row_result_valid in IDLE or DONE sets stray_result, which stays set until reset or the next start_mxv; when undefined, stray_result is tied to 0 and no check logic is built.

Verification
REQ-032 reset low then high; start_mxv with no_of_rows=3; valid strobes with 0x11,0x22,0x33 -> mxv_done pulses once in the cycle after the 3rd strobe; rd_addr 0..2 returns 0x11,0x22,0x33.
REQ-033 start_mxv with no_of_rows=0 -> results_valid=1 and mxv_done pulses the next cycle; row_index stays 0; no buffer write.
REQ-034 Two of four rows collected, then start_mxv with no_of_rows=2 asserted in the same cycle as a valid strobe carrying 0xAA -> 0xAA is not written; row_index=0; two further strobes 0x01,0x02 -> mxv_done; addresses 0,1 hold 0x01,0x02.
REQ-035 reset asserted after 5 of 64 rows collected -> all outputs return to reset values asynchronously; after release, stray strobes are ignored until start_mxv.
REQ-036 With MXV_COLLECT_STRAY_CHECK_EN defined: a valid strobe in DONE -> stray_result=1 and the buffer is unchanged; the next start_mxv clears it. Without the macro, the same stimulus leaves stray_result at 0.
REQ-037 start_mxv with no_of_rows=64 and 64 back-to-back strobes (value = index) -> mxv_done after the 64th; rd_addr 63 returns 63; row_index=64.
